mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: CPU data and address width.
REQ-002 Parameter WAIT_STATES, default 1, range 0..15: extra memory cycles per access.
REQ-003 Parameter ADDR_BITS, default 10: word-address width presented to memory.
REQ-004 The block SHALL have one clock, clk_i; reset is asynchronous and active-low, reset_i.
REQ-005 clk_i  in  1  system clock, rising edge.
REQ-006 reset_i  in  1  asynchronous reset, active low.
REQ-007 mem_rd_i  in  1  read request, active low (from ControlMatrix).
REQ-008 mem_wr_i  in  1  write request, active low.
REQ-009 addr_i  in  DATA_WIDTH  byte address.
REQ-010 wdata_i  in  DATA_WIDTH  store data, right-justified.
REQ-011 funct3_i  in  3  access size/sign (LB=000, LH=001, LW=010, LBU=100, LHU=101; stores use 000/001/010).
REQ-012 mem_busy_o  out  1  access in progress, active high.
REQ-013 rdata_o  out  DATA_WIDTH  formatted load data, registered.
REQ-014 misalign_o  out  1  sticky misaligned-access flag (see Configuration).
REQ-015 ram_addr_o  out  ADDR_BITS  word address = addr_i[ADDR_BITS+1:2], latched.
REQ-016 ram_be_o  out  4  byte enables.
REQ-017 ram_we_o / ram_re_o  out  1 each  memory write/read strobes, active high.
REQ-018 ram_wdata_o  out  32  lane-positioned store data.
REQ-019 ram_rdata_i  in  32  raw memory word.

Function
REQ-020 FSM states IDLE, ACCESS, DONE.
REQ-021 IDLE: if mem_wr_i==0 or mem_rd_i==0 at a rising edge, latch addr, funct3, wdata, op; go to ACCESS; wait counter loaded with WAIT_STATES.
REQ-022 Both requests low simultaneously: write SHALL take priority; read ignored.
REQ-023 ACCESS: ram_re_o or ram_we_o asserted every cycle; counter decrements; at counter==0 go to DONE.
REQ-024 DONE: for a read, rdata_o registered from formatted ram_rdata_i; strobes deasserted; next state IDLE.
REQ-025 mem_busy_o SHALL be 1 in ACCESS and DONE, 0 in IDLE; total busy cycles = WAIT_STATES+2.
REQ-026 rdata_o SHALL hold its value until the next read completes; writes do not alter it.
REQ-027 Load formatting: LB/LBU select byte addr[1:0], LH/LHU select half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes word.
REQ-028 Store enables: SB -> be = 0001<<addr[1:0], data byte replicated x4; SH -> be = 0011<<(2*addr[1]), half replicated x2; SW -> be 1111.
REQ-029 Undefined funct3 (011,110,111) SHALL be treated as LW/SW.
REQ-030 Requests arriving while busy SHALL be ignored (no queueing).

Reset
REQ-031 reset_i low SHALL immediately force state IDLE, mem_busy_o 0, ram_we_o 0, ram_re_o 0, ram_be_o 0, rdata_o 0, misalign_o 0, ram_addr_o 0.
REQ-032 Reset mid-access SHALL abort the access with no write completion after reset assertion.

Configuration
REQ-033 Macro MEM_MISALIGN_TRAP_EN defined: halfword access with addr[0]=1 or word access with addr[1:0]!=0 SHALL set misalign_o (sticky until reset), issue no ram strobes, and still complete the busy sequence with rdata_o unchanged.
REQ-034 Macro undefined: misalign_o tied 0; offending low address bits are forced to 0 (aligned access performed).

Structure
REQ-035 funct3 encodings and the state enum (MemBusState) SHALL live in the shared definitions package with the existing CPU enums.
REQ-036 Sub-module mem_lane_fmt (combinational load extract/extend and store be/data replication) is natural; the FSM stays in mem_bus_ctrl.

Verification
REQ-037 WAIT_STATES=1, LW addr 0x008, ram word 0xDEADBEEF -> busy high 3 cycles, ram_addr_o=2, rdata_o=0xDEADBEEF.
REQ-038 LB addr 0x003, word 0x80112233 -> rdata_o 0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 SH addr 0x006, wdata 0x0000ABCD -> ram_be_o 1100, ram_wdata_o 0xABCDABCD, ram_we_o high WAIT_STATES+1 cycles.
REQ-040 mem_rd_i and mem_wr_i low together, SB addr 0x001 -> write performed, be 0010, rdata_o unchanged.
REQ-041 reset_i low during ACCESS of SW -> ram_we_o drops same cycle, busy 0, state IDLE.
REQ-042 With MEM_MISALIGN_TRAP_EN, LW addr 0x002 -> misalign_o=1, no ram_re_o; without it, ram_addr_o=0 and aligned read returned.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// ============================================================================
// Module      : mem_bus_ctrl_pkg
// Description : Shared CPU definitions: load/store funct3 encodings, access
//               size codes and the memory bus controller state enum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // funct3[1:0] carries the access size; funct3[2] selects zero-extension
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } MemBusState;

endpackage

`default_nettype wire

// File: rtl/mem_lane_fmt.sv
// ============================================================================
// Module      : mem_lane_fmt
// Description : Combinational byte-lane formatter: load extract/extend and
//               store byte-enable / data replication for a 32-bit memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_fmt
    import mem_bus_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] ram_word,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = ram_word[{offset, 3'b000} +: 8];
    assign w_half = offset[1] ? ram_word[31:16] : ram_word[15:0];

    always_comb begin
        be         = 4'b1111;
        lane_wdata = store_data;
        load_data  = ram_word;
        case (funct3[1:0])
            SZ_BYTE: begin
                be         = 4'b0001 << offset;
                lane_wdata = {4{store_data[7:0]}};
                load_data  = funct3[2] ? {24'd0, w_byte}
                                       : {{24{w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                be         = 4'b0011 << {offset[1], 1'b0};
                lane_wdata = {2{store_data[15:0]}};
                load_data  = funct3[2] ? {16'd0, w_half}
                                       : {{16{w_half[15]}}, w_half};
            end
            // Word and all undefined encodings fall through as a full word
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
// ============================================================================
// Module      : mem_bus_ctrl
// Description : CPU-to-RAM bus controller with programmable wait states and
//               sized/sign-extended loads. Optional macro
//               MEM_MISALIGN_TRAP_EN traps misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_BITS   = 10
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  mem_rd_i,
    input  logic                  mem_wr_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [2:0]            funct3_i,
    output logic                  mem_busy_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misalign_o,
    output logic [ADDR_BITS-1:0]  ram_addr_o,
    output logic [3:0]            ram_be_o,
    output logic                  ram_we_o,
    output logic                  ram_re_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_STATES);

    MemBusState             r_state;
    MemBusState             w_next_state;
    logic [3:0]             r_wait_cnt;
    logic                   r_is_write;
    logic [2:0]             r_funct3;
    logic [1:0]             r_offset;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [31:0]            r_wdata;
    logic [DATA_WIDTH-1:0]  r_rdata;

    logic                   w_start;
    logic                   w_is_half;
    logic                   w_is_word;
    logic [1:0]             w_offset;
    logic                   w_trap;
    logic                   w_strobe;
    logic [3:0]             w_be;
    logic [31:0]            w_lane_wdata;
    logic [31:0]            w_load;
    logic [DATA_WIDTH-1:0]  w_load_ext;

    assign w_start   = (r_state == IDLE) && (!mem_wr_i || !mem_rd_i);
    assign w_is_half = (funct3_i[1:0] == SZ_HALF);
    assign w_is_word = funct3_i[1];

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_trap;
    logic r_misalign;

    assign w_misaligned = (w_is_half && addr_i[0]) ||
                          (w_is_word && (addr_i[1:0] != 2'b00));
    assign w_offset     = addr_i[1:0];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_trap     <= 1'b0;
            r_misalign <= 1'b0;
        end else if (w_start) begin
            r_trap <= w_misaligned;
            if (w_misaligned) begin
                r_misalign <= 1'b1;
            end
        end
    end

    assign w_trap     = r_trap;
    assign misalign_o = r_misalign;
`else
    // Misaligned low address bits are dropped so the aligned access proceeds
    assign w_offset   = w_is_word ? 2'b00 :
                        w_is_half ? {addr_i[1], 1'b0} : addr_i[1:0];
    assign w_trap     = 1'b0;
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (!mem_wr_i || !mem_rd_i) w_next_state = ACCESS;
            ACCESS:  if (r_wait_cnt == 4'd0)     w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wait_cnt <= 4'd0;
            r_is_write <= 1'b0;
            r_funct3   <= 3'd0;
            r_offset   <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_rdata    <= '0;
        end else begin
            if (w_start) begin
                r_wait_cnt <= C_WAIT_LOAD;
                r_is_write <= !mem_wr_i;
                r_funct3   <= funct3_i;
                r_offset   <= w_offset;
                r_addr     <= addr_i[ADDR_BITS+1:2];
                r_wdata    <= wdata_i[31:0];
            end else if ((r_state == ACCESS) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if ((r_state == DONE) && !r_is_write && !w_trap) begin
                r_rdata <= w_load_ext;
            end
        end
    end

    mem_lane_fmt u_lane_fmt (
        .funct3     (r_funct3),
        .offset     (r_offset),
        .store_data (r_wdata),
        .ram_word   (ram_rdata_i),
        .be         (w_be),
        .lane_wdata (w_lane_wdata),
        .load_data  (w_load)
    );

    generate
        if (DATA_WIDTH > 32) begin : g_rdata_ext
            assign w_load_ext = {{(DATA_WIDTH-32){!r_funct3[2] && w_load[31]}}, w_load};
            logic w_unused_wdata;
            assign w_unused_wdata = ^wdata_i[DATA_WIDTH-1:32];
        end else begin : g_rdata_native
            assign w_load_ext = w_load;
        end
        if (DATA_WIDTH > ADDR_BITS + 2) begin : g_addr_unused
            logic w_unused_addr;
            assign w_unused_addr = ^addr_i[DATA_WIDTH-1:ADDR_BITS+2];
        end
    endgenerate

    assign w_strobe    = (r_state == ACCESS) && !w_trap;
    assign ram_we_o    = w_strobe && r_is_write;
    assign ram_re_o    = w_strobe && !r_is_write;
    assign ram_be_o    = w_strobe ? w_be : 4'b0000;
    assign ram_wdata_o = w_lane_wdata;
    assign ram_addr_o  = r_addr;
    assign rdata_o     = r_rdata;
    assign mem_busy_o  = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
// ============================================================================
// Module      : tb_mem_bus_ctrl
// Description : Directed self-checking bench for mem_bus_ctrl (WAIT_STATES=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_ctrl;

    logic        clk_i;
    logic        reset_i;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [2:0]  funct3_i;
    logic        mem_busy_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic [9:0]  ram_addr_o;
    logic [3:0]  ram_be_o;
    logic        ram_we_o;
    logic        ram_re_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;

    int n_assert = 0;
    int n_fail   = 0;

    int          busy_cycles;
    int          we_cycles;
    int          re_cycles;
    logic [3:0]  seen_be;
    logic [31:0] seen_wdata;
    logic [9:0]  seen_addr;

    mem_bus_ctrl #(
        .DATA_WIDTH  (32),
        .WAIT_STATES (1),
        .ADDR_BITS   (10)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .mem_rd_i    (mem_rd_i),
        .mem_wr_i    (mem_wr_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .funct3_i    (funct3_i),
        .mem_busy_o  (mem_busy_o),
        .rdata_o     (rdata_o),
        .misalign_o  (misalign_o),
        .ram_addr_o  (ram_addr_o),
        .ram_be_o    (ram_be_o),
        .ram_we_o    (ram_we_o),
        .ram_re_o    (ram_re_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, then watch the whole busy window (bounded).
    // intrude drives a write request throughout the busy window.
    task automatic run_access(input logic wr, input logic rd, input logic [31:0] a,
                              input logic [2:0] f3, input logic [31:0] wd,
                              input logic intrude);
        @(negedge clk_i);
        addr_i   = a;
        funct3_i = f3;
        wdata_i  = wd;
        mem_wr_i = ~wr;
        mem_rd_i = ~rd;
        @(negedge clk_i);
        mem_wr_i = intrude ? 1'b0 : 1'b1;
        mem_rd_i = 1'b1;
        busy_cycles = 0;
        we_cycles   = 0;
        re_cycles   = 0;
        seen_be     = 4'b0000;
        seen_wdata  = 32'd0;
        seen_addr   = 10'd0;
        for (int i = 0; i < 40 && mem_busy_o; i++) begin
            busy_cycles++;
            if (ram_we_o) begin
                we_cycles++;
                seen_be    = ram_be_o;
                seen_wdata = ram_wdata_o;
            end
            if (ram_re_o) begin
                re_cycles++;
                seen_be = ram_be_o;
            end
            seen_addr = ram_addr_o;
            @(negedge clk_i);
        end
        mem_wr_i = 1'b1;
    endtask

    initial begin
        reset_i     = 1'b0;
        mem_rd_i    = 1'b1;
        mem_wr_i    = 1'b1;
        addr_i      = 32'd0;
        wdata_i     = 32'd0;
        funct3_i    = 3'd0;
        ram_rdata_i = 32'd0;

        repeat (2) @(negedge clk_i);
        check("rst_busy",     {31'd0, mem_busy_o}, 32'd0);
        check("rst_rdata",    rdata_o, 32'd0);
        check("rst_addr",     {22'd0, ram_addr_o}, 32'd0);
        check("rst_strobes",  {28'd0, ram_be_o, ram_we_o, ram_re_o} >> 2, 32'd0);
        check("rst_misalign", {31'd0, misalign_o}, 32'd0);
        reset_i = 1'b1;

        // LW 0x008
        ram_rdata_i = 32'hDEADBEEF;
        run_access(1'b0, 1'b1, 32'h008, 3'b010, 32'd0, 1'b0);
        check("lw_busy_cycles", busy_cycles, 3);
        check("lw_re_cycles",   re_cycles, 2);
        check("lw_ram_addr",    {22'd0, seen_addr}, 32'd2);
        check("lw_be",          {28'd0, seen_be}, 32'hF);
        check("lw_rdata",       rdata_o, 32'hDEADBEEF);

        // Byte loads, signed and unsigned
        ram_rdata_i = 32'h80112233;
        run_access(1'b0, 1'b1, 32'h003, 3'b000, 32'd0, 1'b0);
        check("lb_rdata", rdata_o, 32'hFFFFFF80);
        check("lb_be",    {28'd0, seen_be}, 32'h8);
        run_access(1'b0, 1'b1, 32'h003, 3'b100, 32'd0, 1'b0);
        check("lbu_rdata", rdata_o, 32'h00000080);

        // Half loads
        run_access(1'b0, 1'b1, 32'h002, 3'b001, 32'd0, 1'b0);
        check("lh_rdata", rdata_o, 32'hFFFF8011);
        run_access(1'b0, 1'b1, 32'h000, 3'b101, 32'd0, 1'b0);
        check("lhu_rdata", rdata_o, 32'h00002233);

        // SH 0x006
        run_access(1'b1, 1'b0, 32'h006, 3'b001, 32'h0000ABCD, 1'b0);
        check("sh_be",         {28'd0, seen_be}, 32'hC);
        check("sh_wdata",      seen_wdata, 32'hABCDABCD);
        check("sh_we_cycles",  we_cycles, 2);
        check("sh_busy",       busy_cycles, 3);
        check("sh_ram_addr",   {22'd0, seen_addr}, 32'd1);
        check("sh_rdata_hold", rdata_o, 32'h00002233);

        // Both requests low: write wins
        ram_rdata_i = 32'h11111111;
        run_access(1'b1, 1'b1, 32'h001, 3'b000, 32'h0000005A, 1'b0);
        check("sb_be",         {28'd0, seen_be}, 32'h2);
        check("sb_wdata",      seen_wdata, 32'h5A5A5A5A);
        check("sb_we_cycles",  we_cycles, 2);
        check("sb_re_cycles",  re_cycles, 0);
        check("sb_rdata_hold", rdata_o, 32'h00002233);

        // Undefined funct3 behaves as a word load
        ram_rdata_i = 32'h12345678;
        run_access(1'b0, 1'b1, 32'h00C, 3'b011, 32'd0, 1'b0);
        check("f3_011_rdata", rdata_o, 32'h12345678);
        check("f3_011_be",    {28'd0, seen_be}, 32'hF);

        // Write request during busy window is ignored
        ram_rdata_i = 32'hCAFEF00D;
        run_access(1'b0, 1'b1, 32'h020, 3'b010, 32'd0, 1'b1);
        check("busy_ignore_we",    we_cycles, 0);
        check("busy_ignore_busy",  busy_cycles, 3);
        check("busy_ignore_rdata", rdata_o, 32'hCAFEF00D);
        check("busy_ignore_addr",  {22'd0, seen_addr}, 32'd8);
        @(negedge clk_i);
        check("busy_ignore_idle",  {31'd0, mem_busy_o}, 32'd0);

        // Reset in the middle of a word store
        @(negedge clk_i);
        addr_i   = 32'h010;
        funct3_i = 3'b010;
        wdata_i  = 32'h55AA55AA;
        mem_wr_i = 1'b0;
        @(negedge clk_i);
        mem_wr_i = 1'b1;
        check("sw_we_active", {31'd0, ram_we_o}, 32'd1);
        #1 reset_i = 1'b0;
        #1;
        check("rst_mid_we",    {31'd0, ram_we_o}, 32'd0);
        check("rst_mid_busy",  {31'd0, mem_busy_o}, 32'd0);
        check("rst_mid_rdata", rdata_o, 32'd0);
        check("rst_mid_addr",  {22'd0, ram_addr_o}, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rst_mid_stays_idle", {30'd0, mem_busy_o, ram_we_o}, 32'd0);

        // Misaligned word load at 0x002
        ram_rdata_i = 32'hAABBCCDD;
        run_access(1'b0, 1'b1, 32'h002, 3'b010, 32'd0, 1'b0);
        check("mis_busy",     busy_cycles, 3);
        check("mis_ram_addr", {22'd0, seen_addr}, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_flag",     {31'd0, misalign_o}, 32'd1);
        check("mis_re",       re_cycles, 0);
        check("mis_rdata",    rdata_o, 32'd0);
`else
        check("mis_flag",     {31'd0, misalign_o}, 32'd0);
        check("mis_re",       re_cycles, 2);
        check("mis_rdata",    rdata_o, 32'hAABBCCDD);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
